// File: rtl/hi_lo_mult_div.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit producing the 64-bit {HI,LO} value.
// One radix-2 shift-add / restoring-divide step per cycle, sign fix-up in a final state.
module hi_lo_mult_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        bz_q, bz_d;
  logic [31:0] aorig_q, aorig_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [63:0] res_q, res_d;

  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] rem_sh, trial;
  logic [63:0] div_nxt;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] fix_res;

  // Only the signed ops (op[0]==0) see their operands as two's complement.
  assign a_neg = ~op_i[0] & a_i[31];
  assign b_neg = ~op_i[0] & b_i[31];
  assign mag_a = a_neg ? -a_i : a_i;
  assign mag_b = b_neg ? -b_i : b_i;

  // Multiply: acc = {hi, multiplier}; add multiplicand into hi, then shift right with carry.
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_nxt = {mul_sum, acc_q[31:1]};

  // Divide: acc = {rem, quo}; the shifted-out bit keeps the trial subtract 33 bits wide.
  assign rem_sh  = acc_q[63:31];
  assign trial   = rem_sh - {1'b0, opnd_q};
  assign div_nxt = trial[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                             : {trial[31:0],  acc_q[30:0], 1'b1};

  assign quo_fix = (sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix = sa_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    fix_res = 64'h0;
    if (!div_q)    fix_res = (sa_q ^ sb_q) ? -acc_q : acc_q;
    else if (bz_q) fix_res = {aorig_q, 32'hFFFF_FFFF};
    else           fix_res = {rem_fix, quo_fix};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    aorig_d = aorig_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    if (flush_i) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            cnt_d   = 5'd0;
            div_d   = op_i[1];
            sa_d    = a_neg;
            sb_d    = b_neg;
            bz_d    = (b_i == 32'h0);
            aorig_d = a_i;
            opnd_d  = op_i[1] ? mag_b : mag_a;
            acc_d   = {32'h0, op_i[1] ? mag_a : mag_b};
          end
        end
        S_RUN: begin
          acc_d = div_q ? div_nxt : mul_nxt;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          res_d   = fix_res;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      aorig_q <= 32'h0;
      opnd_q  <= 32'h0;
      acc_q   <= 64'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      aorig_q <= aorig_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = res_q;

endmodule
